// File: rtl/colorbar_pattern_gen_if.sv
// Parallel-video output bundle: data enable, RGB888 pixel and the two syncs.
// The pattern generator drives it through the master modport. A sink such as
// the DSI bridge or a checker reads it through the slave modport.
interface colorbar_pattern_gen_if;
    logic        lv;
    logic [23:0] data;
    logic        vsync;
    logic        hsync;

    modport master (output lv, output data, output vsync, output hsync);
    modport slave  (input  lv, input  data, input  vsync, input  hsync);
endinterface

// File: rtl/colorbar_pattern_gen.sv
// Free-running raster timing generator with an RGB888 test pattern.
// The pattern is either 8 vertical colour bars (mode=1) or a horizontal grey ramp (mode=0).
// Every output is registered from the counter state, so the outputs lag the counters by one clock.
module colorbar_pattern_gen #(
    parameter int h_active      = 480,
    parameter int h_total       = 800,
    parameter int v_active      = 800,
    parameter int v_total       = 830,
    parameter int H_FRONT_PORCH = 120,
    parameter int H_SYNCH       = 96,
    parameter int V_FRONT_PORCH = 40,
    parameter int V_SYNCH       = 5,
    parameter bit mode          = 1'b1
) (
    input  logic                    m148_5_clk,
    input  logic                    rstn,
    colorbar_pattern_gen_if.master  vid
);

    // Sync pulses start after the front porch. They are pulled earlier when
    // the porch would push the pulse past the end of the line or frame.
    localparam int HS0_I = (h_active + H_FRONT_PORCH < h_total - H_SYNCH) ?
                           (h_active + H_FRONT_PORCH) : (h_total - H_SYNCH);
    localparam int VS0_I = (v_active + V_FRONT_PORCH < v_total - V_SYNCH) ?
                           (v_active + V_FRONT_PORCH) : (v_total - V_SYNCH);

    localparam logic [11:0] H_ACT    = 12'(h_active);
    localparam logic [11:0] H_LAST   = 12'(h_total - 1);
    localparam logic [11:0] V_ACT    = 12'(v_active);
    localparam logic [11:0] V_LAST   = 12'(v_total - 1);
    localparam logic [11:0] HS0      = 12'(HS0_I);
    localparam logic [11:0] HS1      = 12'(HS0_I + H_SYNCH);
    localparam logic [11:0] VS0      = 12'(VS0_I);
    localparam logic [11:0] VS1      = 12'(VS0_I + V_SYNCH);
    localparam logic [11:0] BAR_LAST = 12'(h_active / 8 - 1);

    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic [11:0] bar_pos;   // pixel offset inside the current bar
    logic [2:0]  bar_idx;   // current bar; stays at 7 for remainder pixels

    logic        lv_d,    lv_q;
    logic        hsync_d, hsync_q;
    logic        vsync_d, vsync_q;
    logic [23:0] data_d,  data_q;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 24'hFFFFFF;  // white
            3'd1:    bar_color = 24'hFFFF00;  // yellow
            3'd2:    bar_color = 24'h00FFFF;  // cyan
            3'd3:    bar_color = 24'h00FF00;  // green
            3'd4:    bar_color = 24'hFF00FF;  // magenta
            3'd5:    bar_color = 24'hFF0000;  // red
            3'd6:    bar_color = 24'h0000FF;  // blue
            default: bar_color = 24'h000000;  // black
        endcase
    endfunction

    // Raster counters. The line wraps into the next line and the last line wraps the frame.
    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
    always_ff @(posedge m148_5_clk or negedge rstn) begin
        if (!rstn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
        end else begin
            hcnt <= hcnt + 12'd1;
        end
    end

    // Bar tracker. It follows hcnt and replaces a runtime divide by BAR_W.
    // It restarts with every line.
    always_ff @(posedge m148_5_clk or negedge rstn) begin
        if (!rstn) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (hcnt == H_LAST) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (bar_idx != 3'd7) begin
            if (bar_pos == BAR_LAST) begin
                bar_pos <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pos <= bar_pos + 12'd1;
            end
        end
    end

    // Decode the next output values from the current counter state.
    // NOTE: every signal gets a default first, so this block cannot infer a latch.
    always_comb begin
        lv_d    = (hcnt < H_ACT) && (vcnt < V_ACT);
        hsync_d = (hcnt >= HS0) && (hcnt < HS1);
        vsync_d = (vcnt >= VS0) && (vcnt < VS1);
        data_d  = 24'h0;
        if (lv_d) begin
            if (mode) data_d = bar_color(bar_idx);
            else      data_d = {3{hcnt[7:0]}};
        end
    end

    // Output register. This gives one clock of latency, and reset clears the outputs at once.
    always_ff @(posedge m148_5_clk or negedge rstn) begin
        if (!rstn) begin
            lv_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            data_q  <= 24'h0;
        end else begin
            lv_q    <= lv_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            data_q  <= data_d;
        end
    end

    assign vid.lv    = lv_q;
    assign vid.hsync = hsync_q;
    assign vid.vsync = vsync_q;
    assign vid.data  = data_q;

endmodule

// File: tb/tb_colorbar_pattern_gen.sv
// Directed bench for colorbar_pattern_gen. It drives three instances from one clock and one reset:
//   a: default raster, colour bars  (line timing, bar sequence)
//   b: default raster, grey ramp    (ramp values, wrap at pixel 256)
//   s: shrunken raster, colour bars (whole frames, clamped vsync, bar remainder, mid-frame reset)
// Shrunken raster: 18 active / 26 total pixels, 6 active / 10 total lines.
//   BAR_W=2, so bar 7 covers pixels 14..17.
//   hsync runs on pixels 20..23: min(18+2, 26-4) = 20, width 4.
//   vsync runs on lines 7..9: min(6+2, 10-3) = 7 (clamped), height 3.
//   The frame period is 260 clocks.
module tb_colorbar_pattern_gen;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    colorbar_pattern_gen_if a_if ();
    colorbar_pattern_gen_if b_if ();
    colorbar_pattern_gen_if s_if ();

    colorbar_pattern_gen u_a (
        .m148_5_clk (clk),
        .rstn       (rstn),
        .vid        (a_if.master)
    );

    colorbar_pattern_gen #(.mode(1'b0)) u_b (
        .m148_5_clk (clk),
        .rstn       (rstn),
        .vid        (b_if.master)
    );

    colorbar_pattern_gen #(
        .h_active(18), .h_total(26), .v_active(6), .v_total(10),
        .H_FRONT_PORCH(2), .H_SYNCH(4), .V_FRONT_PORCH(2), .V_SYNCH(3), .mode(1'b1)
    ) u_s (
        .m148_5_clk (clk),
        .rstn       (rstn),
        .vid        (s_if.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar(input int idx);
        case (idx)
            0:       bar = 24'hFFFFFF;
            1:       bar = 24'hFFFF00;
            2:       bar = 24'h00FFFF;
            3:       bar = 24'h00FF00;
            4:       bar = 24'hFF00FF;
            5:       bar = 24'hFF0000;
            6:       bar = 24'h0000FF;
            default: bar = 24'h000000;
        endcase
    endfunction

    task automatic check_idle(input string when);
        check({when, " a.lv"},    {23'h0, a_if.lv},    24'h0);
        check({when, " a.hsync"}, {23'h0, a_if.hsync}, 24'h0);
        check({when, " a.vsync"}, {23'h0, a_if.vsync}, 24'h0);
        check({when, " a.data"},  a_if.data,           24'h0);
        check({when, " b.lv"},    {23'h0, b_if.lv},    24'h0);
        check({when, " b.data"},  b_if.data,           24'h0);
        check({when, " s.lv"},    {23'h0, s_if.lv},    24'h0);
        check({when, " s.vsync"}, {23'h0, s_if.vsync}, 24'h0);
        check({when, " s.data"},  s_if.data,           24'h0);
    endtask

    // Sample t counts clocks after reset release. Sample t reflects raster position t.
    task automatic check_cycle(input int t);
        int    ah, av, sp, sh, sv, bi;
        logic  lv_e, hs_e, vs_e;
        string ts;
        ts = $sformatf("t=%0d", t);

        // Default raster: 480 active of 800 pixels; hsync on pixels 600..695; lines < 800 active.
        ah   = t % 800;
        av   = t / 800;
        lv_e = (ah < 480) && (av < 800);
        hs_e = (ah >= 600) && (ah < 696);
        check({"a.lv ", ts},    {23'h0, a_if.lv},    {23'h0, lv_e});
        check({"a.hsync ", ts}, {23'h0, a_if.hsync}, {23'h0, hs_e});
        check({"a.vsync ", ts}, {23'h0, a_if.vsync}, 24'h0);
        check({"a.data ", ts},  a_if.data,           lv_e ? bar(ah / 60) : 24'h0);
        check({"b.lv ", ts},    {23'h0, b_if.lv},    {23'h0, lv_e});
        check({"b.data ", ts},  b_if.data,
              lv_e ? {ah[7:0], ah[7:0], ah[7:0]} : 24'h0);

        // Shrunken raster
        sp   = t % 260;
        sh   = sp % 26;
        sv   = sp / 26;
        bi   = (sh / 2 > 7) ? 7 : sh / 2;
        lv_e = (sh < 18) && (sv < 6);
        hs_e = (sh >= 20) && (sh < 24);
        vs_e = (sv >= 7);
        check({"s.lv ", ts},    {23'h0, s_if.lv},    {23'h0, lv_e});
        check({"s.hsync ", ts}, {23'h0, s_if.hsync}, {23'h0, hs_e});
        check({"s.vsync ", ts}, {23'h0, s_if.vsync}, {23'h0, vs_e});
        check({"s.data ", ts},  s_if.data,           lv_e ? bar(bi) : 24'h0);
    endtask

    initial begin
        // Hold reset for 100 clocks; every output must stay at zero.
        rstn = 1'b0;
        repeat (100) @(negedge clk);
        check_idle("reset");
        rstn = 1'b1;

        // First edge after release gives pixel (0,0): lv=1, white.
        @(negedge clk);
        check("first a.lv",   {23'h0, a_if.lv}, 24'h1);
        check("first a.data", a_if.data,        24'hFFFFFF);
        check("first b.data", b_if.data,        24'h000000);
        check_cycle(0);

        // Lines 0..2 of the default raster, and several frames of the shrunken one.
        // The run ends with the shrunken raster mid-frame, on line 4.
        for (int t = 1; t < 1670; t++) begin
            @(negedge clk);
            check_cycle(t);
        end

        // Directed spot checks at the ramp wrap and the bar boundaries.
        // Line 2 of the default raster starts at t=1600; these checks use the current sample, t=1669, h=69.
        check("a.data bar1 line2", a_if.data, 24'hFFFF00);
        check("s.data bar2 line4", s_if.data, 24'h00FFFF);

        // Mid-frame reset, asserted between edges. The outputs must clear before the next clock edge.
        #2 rstn = 1'b0;
        #1;
        check_idle("async clear");
        repeat (3) @(negedge clk);
        check_idle("reset held");
        rstn = 1'b1;

        // Timing restarts at line 0, pixel 0 with no resumption of the old frame.
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            check_cycle(t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
